// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcodes and
// system sub-op codes.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_FETCH2 = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } seq_state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI0 = 4'h8;
  localparam logic [3:0] OP_LDI1 = 4'h9;
  localparam logic [3:0] OP_LDI2 = 4'hA;
  localparam logic [3:0] OP_LDI3 = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_SYS  = 4'hF;

  localparam logic [1:0] SYS_OUT  = 2'b00;
  localparam logic [1:0] SYS_INP  = 2'b01;
  localparam logic [1:0] SYS_HALT = 2'b10;
  localparam logic [1:0] SYS_NOP  = 2'b11;

  // Jumps carry their target in a second byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/instr_sequencer_alu4.sv
// Combinational 4-bit ALU for ops 0x2-0x7; carry is borrow for SUB and zero
// for the logic ops.
module instr_sequencer_alu4
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       c,
  output logic       z
);

  logic [4:0] sum;

  always_comb begin
    result = 4'h0;
    c      = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        result = sum[3:0];
        c      = sum[4];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = 4'h0;
    endcase
    z = (result == 4'h0);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer driving a 4x4-bit register file; fetches
// 8-bit instructions from a byte-wide ROM and holds PC, flags and output port.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] ROM_ADDR,
  output logic       ROM_REQ,
  input  logic       ROM_ACK,
  input  logic [7:0] ROM_DATA,
  output logic [1:0] MAIN_SEL,
  output logic [1:0] SUB_SEL,
  output logic [3:0] REG_IN,
  input  logic [3:0] MAIN_OUT,
  input  logic [3:0] SUB_OUT,
  input  logic [3:0] EXT_IN,
  output logic [3:0] OUT_PORT,
  output logic       OUT_VALID,
  output logic       HALTED,
  output seq_state_e STATE_DBG
);

  // ROM handshake: ROM_REQ is the valid, ROM_ACK the ready. A byte transfers
  // on a rising edge where both are high; until then ROM_ADDR stays put, and
  // ROM_ACK means nothing while ROM_REQ is low.

  seq_state_e state, state_next;
  logic [7:0] pc, pc_next;
  logic [7:0] ir, ir_next;
  logic [7:0] tgt, tgt_next;
  logic       c_flag, c_next;
  logic       z_flag, z_next;
  logic [3:0] out_port, out_port_next;
  logic       out_valid, out_valid_next;
  logic       rom_req;

  logic [3:0] op;
  logic [1:0] d;
  logic [1:0] s;
  logic [3:0] alu_result;
  logic       alu_c;
  logic       alu_z;

  assign op = ir[7:4];
  assign d  = ir[3:2];
  assign s  = ir[1:0];

  instr_sequencer_alu4 u_alu (
    .op     (op),
    .a      (MAIN_OUT),
    .b      (SUB_OUT),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_FETCH;
      pc        <= 8'h00;
      ir        <= 8'h00;
      tgt       <= 8'h00;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out_port  <= 4'h0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      ir        <= ir_next;
      tgt       <= tgt_next;
      c_flag    <= c_next;
      z_flag    <= z_next;
      out_port  <= out_port_next;
      out_valid <= out_valid_next;
    end
  end

  // The register file writes every edge, so every non-writing cycle
  // feeds MAIN_OUT straight back into the selected register.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    ir_next        = ir;
    tgt_next       = tgt;
    c_next         = c_flag;
    z_next         = z_flag;
    out_port_next  = out_port;
    out_valid_next = 1'b0;
    main_sel_q: begin end
    MAIN_SEL       = 2'b00;
    SUB_SEL        = 2'b00;
    REG_IN         = MAIN_OUT;
    rom_req        = 1'b0;
    case (state)
      ST_FETCH: begin
        rom_req = 1'b1;
        if (ROM_ACK) begin
          ir_next    = ROM_DATA;
          pc_next    = pc + 8'd1;
          state_next = is_two_byte(ROM_DATA[7:4]) ? ST_FETCH2 : ST_EXEC;
        end
      end
      ST_FETCH2: begin
        rom_req = 1'b1;
        if (ROM_ACK) begin
          tgt_next   = ROM_DATA;
          pc_next    = pc + 8'd1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        MAIN_SEL   = (op[3:2] == 2'b10) ? ir[5:4] : d;
        SUB_SEL    = s;
        state_next = ST_FETCH;
        case (op)
          OP_NOP: REG_IN = MAIN_OUT;
          OP_MOV: REG_IN = SUB_OUT;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            REG_IN = alu_result;
            c_next = alu_c;
            z_next = alu_z;
          end
          OP_LDI0, OP_LDI1, OP_LDI2, OP_LDI3: REG_IN = ir[3:0];
          OP_JMP: pc_next = tgt;
          OP_JC:  if (c_flag) pc_next = tgt;
          OP_JZ:  if (z_flag) pc_next = tgt;
          OP_SYS: begin
            case (s)
              SYS_OUT: begin
                out_port_next  = MAIN_OUT;
                out_valid_next = 1'b1;
              end
              SYS_INP:  REG_IN = EXT_IN;
              SYS_HALT: state_next = ST_HALT;
              SYS_NOP:  REG_IN = MAIN_OUT;
            endcase
          end
        endcase
      end
      ST_HALT: state_next = ST_HALT;
    endcase
  end

  assign ROM_REQ   = rom_req & ~RESET;
  assign ROM_ADDR  = pc;
  assign OUT_PORT  = out_port;
  assign OUT_VALID = out_valid;
  assign HALTED    = (state == ST_HALT);
  assign STATE_DBG = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural register file and ROM around the DUT,
// an instruction-level reference interpreter, directed and random programs.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       CLK;
  logic       RESET;
  logic [7:0] ROM_ADDR;
  logic       ROM_REQ;
  logic       ROM_ACK;
  logic [7:0] ROM_DATA;
  logic [1:0] MAIN_SEL;
  logic [1:0] SUB_SEL;
  logic [3:0] REG_IN;
  logic [3:0] MAIN_OUT;
  logic [3:0] SUB_OUT;
  logic [3:0] EXT_IN;
  logic [3:0] OUT_PORT;
  logic       OUT_VALID;
  logic       HALTED;
  seq_state_e STATE_DBG;

  instr_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ROM_ADDR  (ROM_ADDR),
    .ROM_REQ   (ROM_REQ),
    .ROM_ACK   (ROM_ACK),
    .ROM_DATA  (ROM_DATA),
    .MAIN_SEL  (MAIN_SEL),
    .SUB_SEL   (SUB_SEL),
    .REG_IN    (REG_IN),
    .MAIN_OUT  (MAIN_OUT),
    .SUB_OUT   (SUB_OUT),
    .EXT_IN    (EXT_IN),
    .OUT_PORT  (OUT_PORT),
    .OUT_VALID (OUT_VALID),
    .HALTED    (HALTED),
    .STATE_DBG (STATE_DBG)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register file: writes REG_IN into MAIN_SEL on every edge
  logic [3:0] rf [4];
  logic       rf_clear;
  always @(posedge CLK) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else begin
      rf[MAIN_SEL] <= REG_IN;
    end
  end
  assign MAIN_OUT = rf[MAIN_SEL];
  assign SUB_OUT  = rf[SUB_SEL];

  // ROM responder and output monitor state
  logic [7:0] rom [256];
  int         rom_budget;
  int         max_wait;
  bit         fixed_wait;
  int         ack_count;
  int         addr_unstable;
  logic [7:0] obs_addr[$];
  logic [3:0] obs_out[$];

  // Scoreboard
  logic [7:0] exp_q[$];
  logic [3:0] exp_out[$];
  int         exp_regs[4];
  bit         exp_halt;
  int         errors;
  int         checks;

  initial begin
    int         wait_left;
    logic [7:0] held_addr;
    ROM_ACK = 1'b0;
    ROM_DATA = 8'h00;
    ack_count = 0;
    addr_unstable = 0;
    wait_left = -1;
    held_addr = 8'h00;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        ack_count = 0;
        addr_unstable = 0;
        wait_left = -1;
        obs_addr.delete();
        obs_out.delete();
        ROM_ACK = 1'($urandom_range(1, 0));
        ROM_DATA = 8'($urandom_range(255, 0));
      end else begin
        if (OUT_VALID) obs_out.push_back(OUT_PORT);
        if (wait_left >= 0 && (!ROM_REQ || ROM_ADDR != held_addr)) addr_unstable++;
        if (ROM_REQ && ack_count < rom_budget) begin
          if (wait_left < 0) begin
            wait_left = fixed_wait ? max_wait : int'($urandom_range(max_wait, 0));
            held_addr = ROM_ADDR;
          end
          if (wait_left == 0) begin
            ROM_ACK = 1'b1;
            ROM_DATA = rom[ROM_ADDR];
            ack_count++;
            obs_addr.push_back(ROM_ADDR);
            wait_left = -1;
          end else begin
            wait_left--;
            ROM_ACK = 1'b0;
            ROM_DATA = 8'($urandom_range(255, 0));
          end
        end else begin
          ROM_ACK = ROM_REQ ? 1'b0 : 1'($urandom_range(1, 0));
          ROM_DATA = 8'($urandom_range(255, 0));
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-level interpreter over the ROM image
  task automatic run_model(input int max_instr, input int ext);
    int pc, c, z, op, d, s, tgt, res, ir;
    int r[4];
    exp_q.delete();
    exp_out.delete();
    pc = 0; c = 0; z = 0; exp_halt = 0;
    for (int i = 0; i < 4; i++) r[i] = 0;
    for (int n = 0; n < max_instr && !exp_halt; n++) begin
      ir = int'(rom[pc]);
      exp_q.push_back(8'(pc));
      pc = (pc + 1) % 256;
      op = ir / 16; d = (ir / 4) % 4; s = ir % 4;
      tgt = 0;
      if (op >= 12 && op <= 14) begin
        tgt = int'(rom[pc]);
        exp_q.push_back(8'(pc));
        pc = (pc + 1) % 256;
      end
      res = -1;
      case (op)
        1: r[d] = r[s];
        2: begin res = r[d] + r[s]; c = (res > 15) ? 1 : 0; res = res % 16; end
        3: begin c = (r[d] < r[s]) ? 1 : 0; res = (r[d] - r[s] + 16) % 16; end
        4: begin res = r[d] & r[s]; c = 0; end
        5: begin res = r[d] | r[s]; c = 0; end
        6: begin res = r[d] ^ r[s]; c = 0; end
        7: begin res = 15 - r[d]; c = 0; end
        8, 9, 10, 11: r[(ir / 16) % 4] = ir % 16;
        12: pc = tgt;
        13: if (c != 0) pc = tgt;
        14: if (z != 0) pc = tgt;
        15: begin
          if (s == 0) exp_out.push_back(4'(r[d]));
          else if (s == 1) r[d] = ext % 16;
          else if (s == 2) exp_halt = 1;
        end
        default: ;
      endcase
      if (res >= 0) begin
        r[d] = res;
        z = (res == 0) ? 1 : 0;
      end
    end
    for (int i = 0; i < 4; i++) exp_regs[i] = r[i];
  endtask

  task automatic start_program(input int max_instr, input int ext, input int mw, input bit fixed);
    run_model(max_instr, ext);
    @(posedge CLK); #2;
    RESET = 1'b1;
    rf_clear = 1'b1;
    EXT_IN = 4'(ext);
    max_wait = mw;
    fixed_wait = fixed;
    rom_budget = exp_q.size();
    @(posedge CLK); #2;
    check("rst_rom_req", 32'(ROM_REQ), 32'd0);
    check("rst_rom_addr", 32'(ROM_ADDR), 32'd0);
    check("rst_halted", 32'(HALTED), 32'd0);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_port", 32'(OUT_PORT), 32'd0);
    RESET = 1'b0;
    rf_clear = 1'b0;
  endtask

  task automatic finish_program(input string tag);
    int cyc;
    cyc = 0;
    while (ack_count < rom_budget && cyc < 3000) begin
      @(posedge CLK); #2;
      cyc++;
    end
    check($sformatf("%s_fetch_count", tag), 32'(ack_count), 32'(rom_budget));
    repeat (4) begin
      @(posedge CLK); #2;
    end
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i),
            (i < obs_addr.size()) ? 32'(obs_addr[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    check($sformatf("%s_out_count", tag), 32'(obs_out.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size(); i++)
      check($sformatf("%s_out%0d", tag, i),
            (i < obs_out.size()) ? 32'(obs_out[i]) : 32'hxxxx_xxxx, 32'(exp_out[i]));
    check($sformatf("%s_out_port", tag), 32'(OUT_PORT),
          (exp_out.size() > 0) ? 32'(exp_out[exp_out.size() - 1]) : 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(rf[i]), 32'(exp_regs[i]));
    check($sformatf("%s_halted", tag), 32'(HALTED), 32'(exp_halt));
    check($sformatf("%s_rom_req", tag), 32'(ROM_REQ), 32'(!exp_halt));
    check($sformatf("%s_addr_stable", tag), 32'(addr_unstable), 32'd0);
  endtask

  task automatic fill_rom(input logic [7:0] b);
    for (int a = 0; a < 256; a++) rom[a] = b;
  endtask

  initial begin
    RESET = 1'b1; rf_clear = 1'b1; EXT_IN = 4'h0;
    max_wait = 0; fixed_wait = 1'b1; rom_budget = 0;
    errors = 0; checks = 0;

    // LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HALT -- zero-wait timing
    fill_rom(8'hF2);
    rom[0] = 8'h95; rom[1] = 8'hA3; rom[2] = 8'h26; rom[3] = 8'hF4;
    start_program(20, 0, 0, 1'b1);
    repeat (5) @(posedge CLK);
    #2 check("p1_r1_before_add", 32'(rf[1]), 32'd5);
    @(posedge CLK); #2;
    check("p1_r1_after_6cyc", 32'(rf[1]), 32'd8);
    finish_program("p1");

    // 0xF+1 sets C and Z, JC 0x40 taken
    fill_rom(8'hF2);
    rom[0] = 8'h8F; rom[1] = 8'h91; rom[2] = 8'h21; rom[3] = 8'hD0; rom[4] = 8'h40;
    rom[5] = 8'hF4; rom[8'h40] = 8'hF0;
    start_program(20, 0, 0, 1'b1);
    finish_program("p2");

    // 2-3 borrows, JZ 0x10 not taken, OUT r0
    fill_rom(8'hF2);
    rom[0] = 8'h82; rom[1] = 8'h93; rom[2] = 8'h31; rom[3] = 8'hE0; rom[4] = 8'h10;
    rom[5] = 8'hF0; rom[8'h10] = 8'hF4;
    start_program(20, 0, 1, 1'b0);
    finish_program("p3");

    // OUT r2=0xA, INP r3 with EXT_IN=6, OUT r3
    fill_rom(8'hF2);
    rom[0] = 8'hAA; rom[1] = 8'hF8; rom[2] = 8'hFD; rom[3] = 8'hFC;
    start_program(20, 6, 2, 1'b0);
    finish_program("p4");

    // JMP 0x20 with every byte delayed three cycles
    fill_rom(8'hF2);
    rom[0] = 8'h87; rom[1] = 8'hC0; rom[2] = 8'h20; rom[3] = 8'h81; rom[8'h20] = 8'hF0;
    start_program(20, 0, 3, 1'b1);
    finish_program("p5");

    // HALT at 0x05 stays halted
    fill_rom(8'h00);
    rom[5] = 8'hF2;
    start_program(20, 0, 0, 1'b1);
    finish_program("p6");
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(posedge CLK);
      #2 check($sformatf("p6_halt_hold%0d", i), 32'({HALTED, ROM_REQ}), 32'b10);
    end

    // Two-byte instruction at 0xFF takes its operand from 0x00
    fill_rom(8'hF2);
    rom[0] = 8'hC0; rom[1] = 8'hFF; rom[8'hFF] = 8'hC0; rom[8'hC0] = 8'hF0;
    start_program(20, 0, 1, 1'b0);
    finish_program("p7");

    // Random programs; unterminated ones are reset while stalled mid-fetch
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(255, 0));
      start_program(30, int'($urandom_range(15, 0)), int'($urandom_range(2, 0)), 1'b0);
      finish_program($sformatf("rnd%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
